// File: rtl/csr_access_ctrl_pkg.sv
// csr_access_ctrl_pkg
//   Shared definitions for the CSR access controller: Zicsr funct3 encodings,
//   the read-only address-field value, the reduced operation type used by the
//   write-data ALU, and small decode helpers shared by the FSM and the ALU.
package csr_access_ctrl_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // csr[11:10] == 2'b11 marks the read-only CSR address space
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    CSR_OP_RW   = 2'd0,
    CSR_OP_RS   = 2'd1,
    CSR_OP_RC   = 2'd2,
    CSR_OP_NONE = 2'd3
  } csr_op_e;

  // Number of bits needed to represent value (clogb2(4095) = 12).
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction

  // funct3[2] only selects the immediate source, so the operation is decoded
  // from the low two bits; 2'b00 covers both reserved encodings 000 and 100.
  function automatic csr_op_e csr_funct3_op(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b01:   return CSR_OP_RW;
      2'b10:   return CSR_OP_RS;
      2'b11:   return CSR_OP_RC;
      default: return CSR_OP_NONE;
    endcase
  endfunction

  // Set/clear with rs1 = x0 (or uimm = 0) must not write, so the decision is
  // taken from the 5-bit rs1 field, never from the operand value.
  function automatic logic csr_op_writes(input csr_op_e op, input logic [4:0] rs1_field);
    case (op)
      CSR_OP_RW:            return 1'b1;
      CSR_OP_RS, CSR_OP_RC: return |rs1_field;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// csr_wdata_alu
//   Combinational write-data generator for one CSR read-modify-write.
//   Ports:
//     op_i        : reduced operation (csr_op_e encoding)
//     rs1_field_i : rs1 index / uimm field, decides whether set/clear write
//     old_i       : current CSR value (0 when the read was suppressed)
//     src_i       : source operand (rs1 value or zero-extended uimm)
//     wdata_o     : value to write into the CSR
//     do_write_o  : the instruction performs a CSR write
module csr_wdata_alu
  import csr_access_ctrl_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [4:0]  rs1_field_i,
  input  logic [31:0] old_i,
  input  logic [31:0] src_i,
  output logic [31:0] wdata_o,
  output logic        do_write_o
);

  always_comb begin
    wdata_o = old_i;
    case (op_i)
      CSR_OP_RW: wdata_o = src_i;
      CSR_OP_RS: wdata_o = old_i | src_i;
      CSR_OP_RC: wdata_o = old_i & ~src_i;
      default:   wdata_o = old_i;
    endcase
  end

  assign do_write_o = csr_op_writes(csr_op_e'(op_i), rs1_field_i);

endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
//   Initiator side of the CSR register-file port. Runs one Zicsr instruction
//   as a read-modify-write against a CSR unit that reads combinationally and
//   writes on the rising clock edge. Illegal accesses report resp_illegal and
//   produce no CSR read or write.
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     req_*                    : execute-stage request (valid/ready)
//     resp_*                   : response to execute stage (valid/ready)
//     csr_r_en, csr_w_en       : registered enables to the CSR unit
//     csr_addr, csr_wdata      : registered address / write data to the CSR unit
//     csr_rdata                : combinational read data from the CSR unit
//
//   state | meaning
//   IDLE  | req_ready=1, waiting for a request
//   READ  | csr_addr driven, csr_r_en high if the read is needed
//   WRITE | csr_w_en high if the instruction writes and is legal
//   RESP  | resp_valid=1, held until resp_ready
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter  int CSR_REG_COUNT = 4096,
  localparam int CSR_ADDR_W    = clogb2(CSR_REG_COUNT - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [11:0]           req_csr,
  input  logic [31:0]           req_rs1_data,
  input  logic [4:0]            req_zimm,
  input  logic                  req_rd_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_illegal,
  output logic                  csr_r_en,
  output logic                  csr_w_en,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]            state_q,        state_d;
  logic [1:0]            op_q,           op_d;
  logic [31:0]           src_q,          src_d;
  logic [4:0]            rs1_field_q,    rs1_field_d;
  logic                  illegal_q,      illegal_d;
  logic                  csr_r_en_q,     csr_r_en_d;
  logic                  csr_w_en_q,     csr_w_en_d;
  logic [CSR_ADDR_W-1:0] csr_addr_q,     csr_addr_d;
  logic [31:0]           csr_wdata_q,    csr_wdata_d;
  logic                  resp_valid_q,   resp_valid_d;
  logic [31:0]           resp_rdata_q,   resp_rdata_d;
  logic                  resp_illegal_q, resp_illegal_d;

  csr_op_e     req_op;
  logic        req_writes;
  logic        req_out_of_range;
  logic        req_illegal;
  logic        req_reads;
  logic [31:0] req_src;
  logic [31:0] old_val;
  logic [31:0] alu_wdata;
  logic        alu_do_write;

  // ---------------------------------------------------------------------------
  // Request decode (used only on the accepting edge)
  // ---------------------------------------------------------------------------
  assign req_op     = csr_funct3_op(req_funct3[1:0]);
  assign req_writes = csr_op_writes(req_op, req_zimm);
  assign req_src    = req_funct3[2] ? {27'b0, req_zimm} : req_rs1_data;

  // With the full 12-bit space implemented no address can be out of range.
  if (CSR_REG_COUNT >= 4096) begin : g_full_range
    assign req_out_of_range = 1'b0;
  end else begin : g_part_range
    assign req_out_of_range = (32'(req_csr) >= 32'(CSR_REG_COUNT));
  end

  assign req_illegal = (req_op == CSR_OP_NONE) || req_out_of_range ||
                       (req_writes && (req_csr[11:10] == CSR_RO_FIELD));

  // CSRRW/CSRRWI with rd = x0 must not read (read side effects).
  assign req_reads = !req_illegal && !((req_op == CSR_OP_RW) && req_rd_zero);

  // ---------------------------------------------------------------------------
  // Write-data ALU, fed from the latched request and the masked read value
  // ---------------------------------------------------------------------------
  assign old_val = csr_r_en_q ? csr_rdata : 32'b0;

  csr_wdata_alu u_wdata_alu (
    .op_i        (op_q),
    .rs1_field_i (rs1_field_q),
    .old_i       (old_val),
    .src_i       (src_q),
    .wdata_o     (alu_wdata),
    .do_write_o  (alu_do_write)
  );

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    src_d          = src_q;
    rs1_field_d    = rs1_field_q;
    illegal_d      = illegal_q;
    csr_r_en_d     = 1'b0;
    csr_w_en_d     = 1'b0;
    csr_addr_d     = csr_addr_q;
    csr_wdata_d    = csr_wdata_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_READ;
          op_d        = req_op;
          src_d       = req_src;
          rs1_field_d = req_zimm;
          illegal_d   = req_illegal;
          csr_addr_d  = req_csr[CSR_ADDR_W-1:0];
          csr_r_en_d  = req_reads;
        end
      end
      ST_READ: begin
        state_d        = ST_WRITE;
        resp_rdata_d   = old_val;
        resp_illegal_d = illegal_q;
        // wdata only moves when a write is actually issued
        if (alu_do_write && !illegal_q) begin
          csr_w_en_d  = 1'b1;
          csr_wdata_d = alu_wdata;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      op_q           <= CSR_OP_NONE;
      src_q          <= 32'b0;
      rs1_field_q    <= 5'b0;
      illegal_q      <= 1'b0;
      csr_r_en_q     <= 1'b0;
      csr_w_en_q     <= 1'b0;
      csr_addr_q     <= '0;
      csr_wdata_q    <= 32'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      src_q          <= src_d;
      rs1_field_q    <= rs1_field_d;
      illegal_q      <= illegal_d;
      csr_r_en_q     <= csr_r_en_d;
      csr_w_en_q     <= csr_w_en_d;
      csr_addr_q     <= csr_addr_d;
      csr_wdata_q    <= csr_wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
  assign csr_r_en     = csr_r_en_q;
  assign csr_w_en     = csr_w_en_q;
  assign csr_addr     = csr_addr_q;
  assign csr_wdata    = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_zimm;
  logic        req_rd_zero;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        csr_r_en;
  logic        csr_w_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int checks;
  int failures;
  int w_cnt;
  int r_cnt;
  int bad_cnt;

  // CSR unit model: combinational read, write on posedge, bench preload port
  logic [31:0] csr_mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  assign csr_rdata = csr_r_en ? csr_mem[csr_addr] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_data;
    else if (csr_w_en) csr_mem[csr_addr] <= csr_wdata;
  end

  always @(posedge clk) begin
    if (csr_w_en) w_cnt++;
    if (csr_r_en) r_cnt++;
    if ((csr_w_en || csr_r_en) && (req_ready || resp_valid)) bad_cnt++;
  end

  csr_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr      (req_csr),
    .req_rs1_data (req_rs1_data),
    .req_zimm     (req_zimm),
    .req_rd_zero  (req_rd_zero),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .csr_r_en     (csr_r_en),
    .csr_w_en     (csr_w_en),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1 pre_en = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the READ cycle.
  task automatic issue_req(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] rs1,
                           input logic [4:0] zimm, input logic rd0, output logic timeout);
    req_funct3 = f3; req_csr = csr; req_rs1_data = rs1; req_zimm = zimm; req_rd_zero = rd0;
    req_valid = 1'b1;
    timeout = 1'b1;
    for (int i = 0; i < 10 && timeout; i++) begin
      if (req_ready) begin
        @(posedge clk); #1 req_valid = 1'b0;
        timeout = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_resp(output int lat, output logic timeout);
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if ({csr_r_en, csr_w_en, resp_illegal} !== 3'b000) begin failures++; $display("FAIL rst_enables got=%b exp=000", {csr_r_en, csr_w_en, resp_illegal}); end
    checks++; if ({csr_addr, csr_wdata} !== 44'h0) begin failures++; $display("FAIL rst_addr_wdata got=%h exp=0", {csr_addr, csr_wdata}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rw();
    logic to;
    int lat, r0, w0;
    preload(12'h340, 32'h1234_5678);
    r0 = r_cnt; w0 = w_cnt;
    issue_req(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5, 1'b0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rw_accept_timeout got=%b exp=0", to); end
    checks++; if (csr_r_en !== 1'b1) begin failures++; $display("FAIL rw_read_en got=%b exp=1", csr_r_en); end
    checks++; if (csr_addr !== 12'h340) begin failures++; $display("FAIL rw_addr got=%h exp=340", csr_addr); end
    checks++; if (csr_w_en !== 1'b0) begin failures++; $display("FAIL rw_w_en_in_read got=%b exp=0", csr_w_en); end
    @(negedge clk);
    checks++; if ({csr_r_en, csr_w_en} !== 2'b01) begin failures++; $display("FAIL rw_write_cycle_en got=%b exp=01", {csr_r_en, csr_w_en}); end
    checks++; if (csr_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_wdata got=%h exp=deadbeef", csr_wdata); end
    wait_resp(lat, to);
    checks++; if (to !== 1'b0 || lat != 1) begin failures++; $display("FAIL rw_resp_latency got=%0d exp=1", lat); end
    checks++; if (resp_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rw_rdata got=%h exp=12345678", resp_rdata); end
    checks++; if (resp_illegal !== 1'b0) begin failures++; $display("FAIL rw_illegal got=%b exp=0", resp_illegal); end
    finish_resp();
    checks++; if (csr_mem[12'h340] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_csr_value got=%h exp=deadbeef", csr_mem[12'h340]); end
    checks++; if (w_cnt - w0 != 1) begin failures++; $display("FAIL rw_w_pulses got=%0d exp=1", w_cnt - w0); end
    checks++; if (r_cnt - r0 != 1) begin failures++; $display("FAIL rw_r_cycles got=%0d exp=1", r_cnt - r0); end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] csr;
    logic [31:0] prior;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic [31:0] exp_new;
    int          exp_w;
  } setclr_vec_t;

  task automatic test_set_clear();
    setclr_vec_t v [5];
    logic to;
    int lat, w0;
    v[0] = '{3'b010, 12'h340, 32'hDEAD_BEEF, 32'h0,         5'd0,  32'hDEAD_BEEF, 0}; // RS x0
    v[1] = '{3'b111, 12'h341, 32'h0000_00FF, 32'h0,         5'h0F, 32'h0000_00F0, 1}; // RCI 0x0F
    v[2] = '{3'b010, 12'h342, 32'h0000_00F0, 32'h0F0F_0000, 5'd3,  32'h0F0F_00F0, 1}; // RS
    v[3] = '{3'b011, 12'h343, 32'hFFFF_0000, 32'h00FF_00FF, 5'd7,  32'hFF00_0000, 1}; // RC
    v[4] = '{3'b110, 12'h344, 32'h0000_0100, 32'hFFFF_FFFF, 5'h11, 32'h0000_0111, 1}; // RSI
    for (int i = 0; i < 5; i++) begin
      preload(v[i].csr, v[i].prior);
      w0 = w_cnt;
      issue_req(v[i].f3, v[i].csr, v[i].rs1, v[i].zimm, 1'b0, to);
      wait_resp(lat, to);
      checks++; if (to !== 1'b0 || lat != 2) begin failures++; $display("FAIL setclr%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (resp_rdata !== v[i].prior) begin failures++; $display("FAIL setclr%0d_rdata got=%h exp=%h", i, resp_rdata, v[i].prior); end
      finish_resp();
      checks++; if (csr_mem[v[i].csr] !== v[i].exp_new) begin failures++; $display("FAIL setclr%0d_csr got=%h exp=%h", i, csr_mem[v[i].csr], v[i].exp_new); end
      checks++; if (w_cnt - w0 != v[i].exp_w) begin failures++; $display("FAIL setclr%0d_w_pulses got=%0d exp=%0d", i, w_cnt - w0, v[i].exp_w); end
    end
  endtask

  task automatic test_rwi_rd_zero();
    logic to;
    int lat, r0, w0;
    preload(12'h345, 32'hAAAA_5555);
    r0 = r_cnt; w0 = w_cnt;
    issue_req(3'b101, 12'h345, 32'h0, 5'd5, 1'b1, to);
    checks++; if (csr_r_en !== 1'b0) begin failures++; $display("FAIL rwi_read_en got=%b exp=0", csr_r_en); end
    wait_resp(lat, to);
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rwi_rdata got=%h exp=0", resp_rdata); end
    finish_resp();
    checks++; if (csr_mem[12'h345] !== 32'h5) begin failures++; $display("FAIL rwi_csr got=%h exp=5", csr_mem[12'h345]); end
    checks++; if (r_cnt - r0 != 0 || w_cnt - w0 != 1) begin failures++; $display("FAIL rwi_counts got=r%0d/w%0d exp=r0/w1", r_cnt - r0, w_cnt - w0); end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] csr;
    logic [4:0]  zimm;
    logic        exp_ill;
    logic [31:0] exp_rdata;
    int          exp_r;
  } ill_vec_t;

  task automatic test_illegal();
    ill_vec_t v [5];
    logic to;
    int lat, r0, w0;
    v[0] = '{3'b001, 12'hC00, 5'd1, 1'b1, 32'h0,         0}; // RW to read-only
    v[1] = '{3'b100, 12'h340, 5'd1, 1'b1, 32'h0,         0}; // reserved funct3
    v[2] = '{3'b000, 12'h340, 5'd0, 1'b1, 32'h0,         0}; // reserved funct3
    v[3] = '{3'b010, 12'hC00, 5'd0, 1'b0, 32'h0000_1111, 1}; // CSRRS x0 on RO: legal read
    v[4] = '{3'b111, 12'hC00, 5'd1, 1'b1, 32'h0,         0}; // RCI nonzero on RO
    preload(12'hC00, 32'h0000_1111);
    for (int i = 0; i < 5; i++) begin
      r0 = r_cnt; w0 = w_cnt;
      issue_req(v[i].f3, v[i].csr, 32'h22, v[i].zimm, 1'b0, to);
      wait_resp(lat, to);
      checks++; if (resp_illegal !== v[i].exp_ill) begin failures++; $display("FAIL ill%0d_flag got=%b exp=%b", i, resp_illegal, v[i].exp_ill); end
      checks++; if (resp_rdata !== v[i].exp_rdata) begin failures++; $display("FAIL ill%0d_rdata got=%h exp=%h", i, resp_rdata, v[i].exp_rdata); end
      finish_resp();
      checks++; if (w_cnt - w0 != 0 || r_cnt - r0 != v[i].exp_r) begin failures++; $display("FAIL ill%0d_access got=r%0d/w%0d exp=r%0d/w0", i, r_cnt - r0, w_cnt - w0, v[i].exp_r); end
    end
    checks++; if (csr_mem[12'hC00] !== 32'h0000_1111 || csr_mem[12'h340] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ill_csr_unchanged got=%h/%h exp=00001111/deadbeef", csr_mem[12'hC00], csr_mem[12'h340]); end
  endtask

  task automatic test_resp_stall();
    logic to;
    int lat, r0, w0;
    preload(12'h346, 32'hCAFE_F00D);
    r0 = r_cnt; w0 = w_cnt;
    issue_req(3'b001, 12'h346, 32'h1, 5'd1, 1'b0, to);
    wait_resp(lat, to);
    req_funct3 = 3'b001; req_csr = 12'h346; req_rs1_data = 32'h77; req_zimm = 5'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL stall%0d_resp got=%b/%h exp=1/cafef00d", i, resp_valid, resp_rdata); end
      checks++; if (req_ready !== 1'b0 || resp_illegal !== 1'b0) begin failures++; $display("FAIL stall%0d_ready_ill got=%b/%b exp=0/0", i, req_ready, resp_illegal); end
    end
    req_valid = 1'b0;
    checks++; if (r_cnt - r0 != 1 || w_cnt - w0 != 1) begin failures++; $display("FAIL stall_access got=r%0d/w%0d exp=r1/w1", r_cnt - r0, w_cnt - w0); end
    finish_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b/%b exp=0/1", resp_valid, req_ready); end
    checks++; if (csr_mem[12'h346] !== 32'h1) begin failures++; $display("FAIL stall_csr got=%h exp=1", csr_mem[12'h346]); end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    logic [31:0] rlog [2];
    int n_acc, n_resp;
    preload(12'h347, 32'h1);
    n_acc = 0; n_resp = 0; acc[0] = 0; acc[1] = 0; rlog[0] = '0; rlog[1] = '0;
    req_funct3 = 3'b110; req_csr = 12'h347; req_rs1_data = 32'h0; req_zimm = 5'h2; req_rd_zero = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid && n_resp < 2) begin rlog[n_resp] = resp_rdata; n_resp++; end
      if (req_valid && req_ready && n_acc < 2) begin
        acc[n_acc] = i; n_acc++;
        @(posedge clk); #1;
        if (n_acc == 1) begin req_funct3 = 3'b111; req_zimm = 5'h1; end
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    checks++; if (n_acc != 2 || acc[1] - acc[0] != 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", acc[1] - acc[0]); end
    checks++; if (n_resp != 2 || rlog[0] !== 32'h1 || rlog[1] !== 32'h3) begin failures++; $display("FAIL b2b_rdata got=%h/%h exp=1/3", rlog[0], rlog[1]); end
    checks++; if (csr_mem[12'h347] !== 32'h2) begin failures++; $display("FAIL b2b_csr got=%h exp=2", csr_mem[12'h347]); end
  endtask

  task automatic test_reset_mid_write();
    logic to;
    int w0;
    preload(12'h348, 32'h0BAD_BEEF);
    issue_req(3'b001, 12'h348, 32'h55, 5'd1, 1'b0, to);
    @(negedge clk);
    checks++; if (csr_w_en !== 1'b1) begin failures++; $display("FAIL midrst_setup_w_en got=%b exp=1", csr_w_en); end
    w0 = w_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL midrst_handshake got=%b/%b exp=1/0", req_ready, resp_valid); end
    checks++; if ({csr_r_en, csr_w_en, resp_illegal} !== 3'b000) begin failures++; $display("FAIL midrst_enables got=%b exp=000", {csr_r_en, csr_w_en, resp_illegal}); end
    checks++; if (csr_addr !== 12'h0 || csr_wdata !== 32'h0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h/%h/%h exp=0/0/0", csr_addr, csr_wdata, resp_rdata); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (csr_mem[12'h348] !== 32'h0BAD_BEEF || w_cnt - w0 != 0) begin failures++; $display("FAIL midrst_no_write got=%h/%0d exp=0badbeef/0", csr_mem[12'h348], w_cnt - w0); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b/%b exp=1/0", req_ready, resp_valid); end
  endtask

  initial begin
    checks = 0; failures = 0; w_cnt = 0; r_cnt = 0; bad_cnt = 0;
    req_valid = 1'b0; req_funct3 = 3'b0; req_csr = 12'h0; req_rs1_data = 32'h0;
    req_zimm = 5'h0; req_rd_zero = 1'b0; resp_ready = 1'b0;
    pre_en = 1'b0; pre_addr = 12'h0; pre_data = 32'h0;
    test_reset();
    test_rw();
    test_set_clear();
    test_rwi_rd_zero();
    test_illegal();
    test_resp_stall();
    test_back_to_back();
    test_reset_mid_write();
    checks++; if (bad_cnt != 0) begin failures++; $display("FAIL enable_outside_access got=%0d exp=0", bad_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
